// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Every access is an IDLE (arbitrate/latch) cycle followed by an ACCESS cycle.
module dmem_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [15:0] m0_rdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [15:0] m1_rdata,
    output logic [15:0] mem_A,
    output logic [15:0] mem_WD,
    output logic        mem_WE,
    output logic        mem_RE,
    input  logic [15:0] mem_RD
);

    localparam int  DATA_W   = 16;
    localparam logic PRIO_RST = (PRIO_INIT != 0);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state_q, state_d;

    logic              prio_q;
    logic              any_req;
    logic              win_sel;
    logic              in_access;
    logic              win_id_p0;
    logic              we_p0;
    logic [DATA_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              m0_vld_p1;
    logic              m1_vld_p1;
    logic [DATA_W-1:0] m0_rdata_p1;
    logic [DATA_W-1:0] m1_rdata_p1;

    assign any_req   = m0_req | m1_req;
    // Contention goes to the priority holder; otherwise the lone requester wins.
    assign win_sel   = (m0_req & m1_req) ? prio_q : m1_req;
    assign in_access = (state_q == ACCESS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: winner's request captured at the edge leaving IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q    <= PRIO_RST;
            win_id_p0 <= 1'b0;
            we_p0     <= 1'b0;
            addr_p0   <= '0;
            wdata_p0  <= '0;
        end else if (state_q == IDLE && any_req) begin
            prio_q    <= ~win_sel;
            win_id_p0 <= win_sel;
            we_p0     <= win_sel ? m1_we    : m0_we;
            addr_p0   <= win_sel ? m1_addr  : m0_addr;
            wdata_p0  <= win_sel ? m1_wdata : m0_wdata;
        end
    end

    // Stage p1: read data captured at the edge ending ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_vld_p1   <= 1'b0;
            m1_vld_p1   <= 1'b0;
            m0_rdata_p1 <= '0;
            m1_rdata_p1 <= '0;
        end else begin
            m0_vld_p1 <= in_access & ~we_p0 & ~win_id_p0;
            m1_vld_p1 <= in_access & ~we_p0 &  win_id_p0;
            if (in_access && !we_p0 && !win_id_p0) m0_rdata_p1 <= mem_RD;
            if (in_access && !we_p0 &&  win_id_p0) m1_rdata_p1 <= mem_RD;
        end
    end

    // Memory strobes decode from state so an async reset kills them at once.
    assign mem_A     = in_access ? addr_p0 : '0;
    assign mem_WE    = in_access &  we_p0;
    assign mem_RE    = in_access & ~we_p0;
    assign mem_WD    = (in_access && we_p0) ? wdata_p0 : '0;
    assign m0_gnt    = in_access & ~win_id_p0;
    assign m1_gnt    = in_access &  win_id_p0;
    assign m0_rvalid = m0_vld_p1;
    assign m1_rvalid = m1_vld_p1;
    assign m0_rdata  = m0_rdata_p1;
    assign m1_rdata  = m1_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: memory model, per-port read scoreboards,
// and per-cycle exclusivity checks.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE, mem_RE;

    dmem_arbiter #(.PRIO_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RE(mem_RE),
        .mem_RD(mem_RD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: word a initially holds a; writes land on the rising edge.
    logic [15:0] mem [0:65535];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'(i);
            mem_ready <= 1'b1;
        end else if (mem_WE) begin
            mem[mem_A] <= mem_WD;
        end
    end
    assign mem_RD = mem[mem_A];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
            if (!we) q0.push_back(ref_rd(a));
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
            if (!we) q1.push_back(ref_rd(a));
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    // Advance one cycle, sample #1 after the edge, retire any read data.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m0_rvalid) begin
            if (q0.size() == 0) chk("m0_rvalid_unexpected", 32'(m0_rvalid), 0);
            else                chk("m0_rdata_sb", 32'(m0_rdata), 32'(q0.pop_front()));
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) chk("m1_rvalid_unexpected", 32'(m1_rvalid), 0);
            else                chk("m1_rdata_sb", 32'(m1_rdata), 32'(q1.pop_front()));
        end
        chk("gnt_both",    32'(m0_gnt & m1_gnt),       0);
        chk("we_re_both",  32'(mem_WE & mem_RE),       0);
        chk("rvalid_both", 32'(m0_rvalid & m1_rvalid), 0);
    endtask

    int unsigned last_gnt;
    int          issued [2];

    initial begin
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        repeat (3) tick();
        chk("rst_m0_gnt",    32'(m0_gnt),    0);
        chk("rst_m1_gnt",    32'(m1_gnt),    0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
        chk("rst_mem_A",     32'(mem_A),     0);
        chk("rst_mem_WD",    32'(mem_WD),    0);
        chk("rst_mem_WE",    32'(mem_WE),    0);
        chk("rst_mem_RE",    32'(mem_RE),    0);
        chk("rst_m0_rdata",  32'(m0_rdata),  0);
        chk("rst_m1_rdata",  32'(m1_rdata),  0);
        rst = 1'b1;
        tick();

        // Simultaneous reads straight after reset: m0 first, m1 two cycles later.
        raise(0, 1'b0, 16'h0001, 16'h0000);
        raise(1, 1'b0, 16'h0002, 16'h0000);
        tick();
        chk("sim_m0_gnt", 32'(m0_gnt), 1);
        chk("sim_m1_gnt", 32'(m1_gnt), 0);
        chk("sim_mem_A0", 32'(mem_A),  32'h0001);
        chk("sim_mem_RE", 32'(mem_RE), 1);
        drop(0);
        tick();
        chk("sim_m0_rvalid", 32'(m0_rvalid), 1);
        chk("sim_m0_rdata",  32'(m0_rdata),  32'h0001);
        chk("sim_m1_wait",   32'(m1_gnt),    0);
        tick();
        chk("sim_m1_gnt",     32'(m1_gnt),    1);
        chk("sim_mem_A1",     32'(mem_A),     32'h0002);
        chk("sim_m0_rv_once", 32'(m0_rvalid), 0);
        drop(1);
        tick();
        chk("sim_m1_rvalid", 32'(m1_rvalid), 1);
        chk("sim_m1_rdata",  32'(m1_rdata),  32'h0002);
        tick();
        chk("sim_m1_rv_once",  32'(m1_rvalid), 0);
        chk("sim_m1_rdata_hold", 32'(m1_rdata), 32'h0002);

        // Single m0 write, then m1 reads it back.
        raise(0, 1'b1, 16'h0003, 16'hBEEF);
        tick();
        chk("wr_m0_gnt", 32'(m0_gnt), 1);
        chk("wr_mem_WE", 32'(mem_WE), 1);
        chk("wr_mem_RE", 32'(mem_RE), 0);
        chk("wr_mem_A",  32'(mem_A),  32'h0003);
        chk("wr_mem_WD", 32'(mem_WD), 32'hBEEF);
        drop(0);
        tick();
        chk("wr_commit",    32'(mem[3]),    32'hBEEF);
        chk("wr_no_rvalid", 32'(m0_rvalid), 0);
        chk("wr_gnt_pulse", 32'(m0_gnt),    0);
        chk("wr_WE_off",    32'(mem_WE),    0);
        ref_mem[16'h0003] = 16'hBEEF;
        raise(1, 1'b0, 16'h0003, 16'h0000);
        tick();
        chk("rb_m1_gnt", 32'(m1_gnt), 1);
        chk("rb_mem_WD", 32'(mem_WD), 0);
        drop(1);
        tick();
        chk("rb_m1_rvalid", 32'(m1_rvalid), 1);
        chk("rb_m1_rdata",  32'(m1_rdata),  32'hBEEF);
        tick();

        // Continuous contention: 8 grants alternating m0, m1, ... two cycles apart.
        issued[0] = 1; issued[1] = 1;
        raise(0, 1'b0, 16'h0100, 16'h0000);
        raise(1, 1'b0, 16'h0200, 16'h0000);
        for (int g = 0; g < 8; g++) begin
            int w;
            w = g % 2;
            tick();
            chk("cont_m0_gnt", 32'(m0_gnt), 32'(w == 0));
            chk("cont_m1_gnt", 32'(m1_gnt), 32'(w == 1));
            if (g > 0) chk("cont_gap", 32'(cyc) - last_gnt, 2);
            last_gnt = 32'(cyc);
            drop(w);
            tick();
            if (issued[w] < 4) begin
                raise(w, 1'b0, 16'((w == 0 ? 16'h0100 : 16'h0200) + issued[w]), 16'h0000);
                issued[w]++;
            end
        end
        tick();

        // Reset mid-ACCESS of an m1 write aborts it.
        raise(1, 1'b1, 16'h0005, 16'h1234);
        tick();
        chk("ab_m1_gnt", 32'(m1_gnt), 1);
        chk("ab_mem_WE", 32'(mem_WE), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ab_WE_drop",  32'(mem_WE),   0);
        chk("ab_gnt_drop", 32'(m1_gnt),   0);
        chk("ab_A_drop",   32'(mem_A),    0);
        chk("ab_WD_drop",  32'(mem_WD),   0);
        chk("ab_m0_rdata", 32'(m0_rdata), 0);
        chk("ab_m1_rdata", 32'(m1_rdata), 0);
        drop(1);
        tick();
        chk("ab_mem5",      32'(mem[5]),    32'(ref_rd(16'h0005)));
        chk("ab_no_rvalid", 32'(m1_rvalid), 0);
        tick();
        rst = 1'b1;
        raise(0, 1'b0, 16'h0006, 16'h0000);
        raise(1, 1'b0, 16'h0007, 16'h0000);
        tick();
        chk("ab_prio_m0", 32'(m0_gnt), 1);
        chk("ab_prio_m1", 32'(m1_gnt), 0);
        drop(0);
        tick();
        tick();
        chk("ab_next_m1", 32'(m1_gnt), 1);
        drop(1);
        tick();
        tick();

        // Top-of-range address, then a request withdrawn before sampling.
        raise(1, 1'b1, 16'hFFFF, 16'hFFFF);
        tick();
        chk("bd_mem_A",  32'(mem_A),  32'hFFFF);
        chk("bd_mem_WD", 32'(mem_WD), 32'hFFFF);
        chk("bd_mem_WE", 32'(mem_WE), 1);
        drop(1);
        tick();
        chk("bd_commit", 32'(mem[16'hFFFF]), 32'hFFFF);
        ref_mem[16'hFFFF] = 16'hFFFF;
        m0_we = 1'b0; m0_addr = 16'h0040; m0_req = 1'b1;
        #3;
        m0_req = 1'b0;
        tick();
        chk("drop_m0_gnt", 32'(m0_gnt), 0);
        chk("drop_mem_A",  32'(mem_A),  0);
        chk("drop_mem_RE", 32'(mem_RE), 0);
        chk("drop_mem_WE", 32'(mem_WE), 0);
        tick();
        chk("drop_rvalid", 32'(m0_rvalid), 0);
        raise(0, 1'b0, 16'hFFFF, 16'h0000);
        tick();
        chk("bd_rd_A", 32'(mem_A), 32'hFFFF);
        drop(0);
        tick();
        chk("bd_rd_data", 32'(m0_rdata), 32'hFFFF);
        repeat (2) tick();

        chk("sb_m0_drained", 32'(q0.size()), 0);
        chk("sb_m1_drained", 32'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, selects which port holds round-robin priority after reset (0 = m0, 1 = m1).
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 Port: m0_req, m1_req  input  1 each  access request, held high until the port's gnt is seen.
REQ-005 Port: m0_we, m1_we  input  1 each  1 = write, 0 = read; held stable while req is high.
REQ-006 Port: m0_addr, m1_addr  input  16 each  word address; held stable while req is high.
REQ-007 Port: m0_wdata, m1_wdata  input  16 each  write data; held stable while req is high.
REQ-008 Port: m0_gnt, m1_gnt  output  1 each  one-cycle pulse, high during the port's ACCESS cycle.
REQ-009 Port: m0_rvalid, m1_rvalid  output  1 each  one-cycle pulse: read data valid.
REQ-010 Port: m0_rdata, m1_rdata  output  16 each  registered read data, held until the next read on that port.
REQ-011 Port: mem_A  output  16  data memory address.
REQ-012 Port: mem_WD  output  16  data memory write data.
REQ-013 Port: mem_WE  output  1  data memory write enable.
REQ-014 Port: mem_RE  output  1  data memory read enable.
REQ-015 Port: mem_RD  input  16  data memory combinational read data.

Function
REQ-016 FSM has two states, IDLE and ACCESS; from IDLE, any sampled req moves it to ACCESS; ACCESS always returns to IDLE.
REQ-017 IDLE: at a rising edge with at least one req high, latch the winner's id, we, addr and wdata into internal registers.
REQ-018 Winner rule:
  - only one port requesting: that port wins;
  - both requesting: the port holding priority wins.
REQ-019 Priority pointer moves to the non-winning port on every grant, regardless of whether the other port was requesting.
REQ-020 ACCESS outputs:
  - mem_A = latched addr;
  - mem_WE = latched we;
  - mem_RE = not latched we;
  - mem_WD = latched wdata on writes, 0 on reads;
  - gnt of the winner = 1.
REQ-021 Outside ACCESS: mem_WE = 0, mem_RE = 0, mem_A = 0, mem_WD = 0, both gnt = 0.
REQ-022 Write timing: data commits to memory at the rising edge that ends ACCESS; the winner's rvalid stays 0.
REQ-023 Read timing: mem_RD is captured into the winner's rdata at the edge ending ACCESS; the winner's rvalid = 1 for exactly the following cycle.
REQ-024 Latency: req first sampled at edge E; gnt is high in cycle E..E+1; rvalid is high in cycle E+1..E+2.
REQ-025 Throughput: at most one access per two cycles, counted across both ports.
REQ-026 The requester deasserts req in the cycle after gnt; a req still high in the IDLE following gnt is treated as a new request.
REQ-027 A req dropped before it is sampled in IDLE produces no memory access and no gnt.
REQ-028 The losing port's request is not latched; it is re-arbitrated in the next IDLE, where it now holds priority, so neither port waits more than one access.
REQ-029 Addresses pass to mem_A unmodified, including 0x0000 and 0xFFFF; no range checking or wrap is applied.
REQ-030 Never: gnt to both ports in one cycle; mem_WE and mem_RE high together; rvalid to both ports in one cycle.

Reset
REQ-031 While rst = 0, asynchronously and immediately:
  - FSM = IDLE and priority = PRIO_INIT;
  - latched registers = 0;
  - all gnt, rvalid, mem_* outputs = 0;
  - m0_rdata = m1_rdata = 0.
REQ-032 Reset asserted during ACCESS aborts the access: a write in flight is not committed (mem_WE drops before the edge), and no rvalid follows.
REQ-033 On release of rst, the first arbitration happens at the first rising edge with rst = 1 and a req high.

Verification
REQ-034 Single write: m0_req = 1, we = 1, addr = 0x0003, wdata = 0xBEEF → m0_gnt for 1 cycle, mem_WE = 1, mem_A = 0x0003, mem_WD = 0xBEEF; a later m1 read of 0x0003 returns m1_rdata = 0xBEEF with m1_rvalid at +2 cycles.
REQ-035 Simultaneous reads after reset (PRIO_INIT = 0): m0 reads 0x0001, m1 reads 0x0002 → m0 granted first and m0_rdata = 0x0001; m1 granted two cycles later and m1_rdata = 0x0002.
REQ-036 Continuous contention for 8 accesses (both req held high, re-raised after each gnt) → grants strictly alternate m0, m1, m0, …; gnt gap = 2 cycles.
REQ-037 rst pulled low mid-ACCESS of an m1 write to 0x0005 (data 0x1234) → outputs 0 immediately, memory[5] unchanged, no m1_rvalid; priority back to PRIO_INIT.
REQ-038 Boundary: m1 writes 0xFFFF to address 0xFFFF → mem_A = 0xFFFF; req dropped before sampling → no gnt and mem_* stay 0.
